decode_ctrl_stage: RTL
======================

// Module: decode_ctrl_stage
// PURPOSE
//  Registered decode stage. Decodes a 32-bit RV32I instruction into the control bundle used by the
//  execute stage, then holds it in a 2-entry skid buffer with valid/ready handshakes on both sides.
//  Sits between the fetch/IF-ID register and the ID/EX register; adds AUIPC, illegal-op detection,
//  flush and an illegal-instruction counter. Optional RV32M decode.
// PARAMETERS
//  XLEN   32  width of pc_i / pc_o
//  CNT_W  8   width of the saturating illegal-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous reset, active low
//  in_valid_i   in   1      upstream instruction valid
//  in_ready_o   out  1      stage can accept; registered, = (buffer not full)
//  instr_i      in   32     instruction word
//  pc_i         in   XLEN   instruction PC
//  flush_i      in   1      kill all buffered entries (branch redirect)
//  out_valid_o  out  1      head entry valid
//  out_ready_i  in   1      downstream accepts head
//  ctrl_o       out  ctrl_bundle_t  head control bundle (fields below)
//  rd_o/rs1_o/rs2_o out 5   register indices of head
//  pc_o         out  XLEN   PC of head
//  illegal_o    out  1      head is an illegal instruction (all write/jump/branch enables forced 0)
//  illegal_cnt_o out CNT_W  count of illegal instructions accepted; saturates at all-ones
// BEHAVIOUR
//  Bundle fields: reg_write, result_src[1:0] (00 ALU,01 MEM,10 PC+4), mem_write, jump, branch,
//   alu_ctrl[3:0], alu_src_b, alu_src_a (1 = PC, AUIPC only), imm_src[2:0], jalr, addr_ctrl[2:0], mul_div.
//  ALU codes: add 0000 sub 0001 and 0010 or 0011 xor 0100 slt 0101 sltu 0110 sll 0111 srl 1000
//   bge 1001 bgeu 1010 sra 1011 bne 1100 passB 1111. imm_src: I 000 S 001 B 010 J 011 U 100.
//  Decode: R, I-ALU (incl. slti 0101/sltiu 0110), load, store, branch, JAL, JALR, LUI, AUIPC
//   (alu_src_a=1, alu_src_b=1, imm U, add). Illegal: unknown opcode; R with funct7 not
//   0000000/0100000 (or 0000001 under M); branch funct3 010/011; load funct3 011/110/111;
//   store funct3 >010; JALR funct3!=000; shift-imm with bad funct7. Illegal -> bundle all-zero, illegal=1.
//  Skid buffer: states EMPTY, ONE, TWO. accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//   EMPTY: accept->ONE. ONE: accept&!pop->TWO; pop&!accept->EMPTY; both->ONE (new entry replaces head).
//   TWO: pop->ONE (skid entry becomes head); in_ready_o=0 so no accept.
//  Latency 1 cycle from accept to out_valid_o; full throughput when out_ready_i held 1.
//  Head outputs stable while out_valid_o & !out_ready_i.
//  flush_i: next state EMPTY regardless of accept/pop that cycle; accepted instr is dropped and
//   not counted. illegal_cnt_o increments on accept of an illegal instr, stops at 2^CNT_W-1.
//  Reset (async, rst_n=0): state EMPTY, out_valid_o=0, in_ready_o=1 after release, ctrl_o/rd/rs/pc=0,
//   illegal_o=0, illegal_cnt_o=0. Reset mid-transfer discards all entries.
// CONFIGURATION
//  RV32M_DECODE_EN defined: R-type funct7=0000001 legal; mul_div=1, alu_ctrl={1'b0,funct3}, result_src=00.
//  Not defined: funct7=0000001 is illegal; mul_div tied 0.
// STRUCTURE
//  ctrl_pkg: opcode localparams, alu_op_e, result_src_e, imm_src_e, ctrl_bundle_t struct.
//  Sub-module ctrl_decode: pure combinational instr -> {ctrl_bundle_t, illegal}; this block registers it.
// TESTING
//  add x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, alu_ctrl=0000, reg_write=1, rd=3.
//  AUIPC x5,0x12345 (0x12345297) -> alu_src_a=1, alu_src_b=1, imm_src=100, alu_ctrl=0000.
//  3 back-to-back instrs, out_ready=0 -> in_ready drops after 2 accepts; release -> order preserved.
//  0xFFFFFFFF accepted 300 times, CNT_W=8 -> illegal_o=1 each, illegal_cnt_o saturates at 255.
//  State TWO + flush_i with in_valid=1 -> next cycle out_valid=0, in_ready=1, cnt unchanged.
//  mul x1,x2,x3 (0x023100B3): with RV32M_DECODE_EN -> mul_div=1; without -> illegal_o=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode types for the decode/control stage: opcodes, ALU/result/immediate
// encodings and the control bundle handed to execute.
package ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
      ALU_XOR   = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111,
      ALU_SRL   = 4'b1000, ALU_BGE  = 4'b1001, ALU_BGEU = 4'b1010, ALU_SRA  = 4'b1011,
      ALU_BNE   = 4'b1100, ALU_PASSB = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
   } imm_src_e;

   typedef struct packed {
      logic        reg_write;
      result_src_e result_src;
      logic        mem_write;
      logic        jump;
      logic        branch;
      alu_op_e     alu_ctrl;
      logic        alu_src_b;
      logic        alu_src_a;
      imm_src_e    imm_src;
      logic        jalr;
      logic [2:0]  addr_ctrl;
      logic        mul_div;
   } ctrl_bundle_t;

   // alt selects the funct7[5] variants (sub / sra); other funct3 values ignore it.
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I instruction decoder producing the execute control bundle.
// Define RV32M_DECODE_EN to accept the RV32M funct7=0000001 R-type group.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [31:0]  instr,
   output ctrl_bundle_t ctrl,
   output logic         illegal,
   output logic [4:0]   rd,
   output logic [4:0]   rs1,
   output logic [4:0]   rs2
);

   logic [6:0]   opcode;
   logic [6:0]   funct7;
   logic [2:0]   funct3;
   ctrl_bundle_t c;
   logic         bad;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   always_comb begin
      c   = '0;
      bad = 1'b0;
      case (opcode)
         OP_R: begin
            c.reg_write = 1'b1;
            if (funct7 == F7_BASE || funct7 == F7_ALT) begin
               c.alu_ctrl = alu_from_funct3(funct3, funct7[5]);
`ifdef RV32M_DECODE_EN
            end else if (funct7 == F7_MULDIV) begin
               c.mul_div  = 1'b1;
               c.alu_ctrl = alu_op_e'({1'b0, funct3});
`endif
            end else begin
               bad = 1'b1;
            end
         end
         OP_I: begin
            c.reg_write = 1'b1;
            c.alu_src_b = 1'b1;
            c.imm_src   = IMM_I;
            c.alu_ctrl  = alu_from_funct3(funct3, 1'b0);
            if (funct3 == 3'b001 && funct7 != F7_BASE)
               bad = 1'b1;
            if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT)        c.alu_ctrl = ALU_SRA;
               else if (funct7 != F7_BASE)  bad = 1'b1;
            end
         end
         OP_LOAD: begin
            c.reg_write  = 1'b1;
            c.result_src = RES_MEM;
            c.alu_src_b  = 1'b1;
            c.imm_src    = IMM_I;
            c.addr_ctrl  = funct3;
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OP_STORE: begin
            c.mem_write = 1'b1;
            c.alu_src_b = 1'b1;
            c.imm_src   = IMM_S;
            c.addr_ctrl = funct3;
            bad = (funct3 > 3'b010);
         end
         OP_BRANCH: begin
            c.branch  = 1'b1;
            c.imm_src = IMM_B;
            case (funct3)
               3'b000:  c.alu_ctrl = ALU_SUB;
               3'b001:  c.alu_ctrl = ALU_BNE;
               3'b100:  c.alu_ctrl = ALU_SLT;
               3'b101:  c.alu_ctrl = ALU_BGE;
               3'b110:  c.alu_ctrl = ALU_SLTU;
               3'b111:  c.alu_ctrl = ALU_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OP_JAL: begin
            c.reg_write  = 1'b1;
            c.result_src = RES_PC4;
            c.jump       = 1'b1;
            c.imm_src    = IMM_J;
         end
         OP_JALR: begin
            c.reg_write  = 1'b1;
            c.result_src = RES_PC4;
            c.jump       = 1'b1;
            c.jalr       = 1'b1;
            c.alu_src_b  = 1'b1;
            c.imm_src    = IMM_I;
            bad = (funct3 != 3'b000);
         end
         OP_LUI: begin
            c.reg_write = 1'b1;
            c.alu_src_b = 1'b1;
            c.imm_src   = IMM_U;
            c.alu_ctrl  = ALU_PASSB;
         end
         OP_AUIPC: begin
            c.reg_write = 1'b1;
            c.alu_src_a = 1'b1;
            c.alu_src_b = 1'b1;
            c.imm_src   = IMM_U;
         end
         default: bad = 1'b1;
      endcase
      // Illegal ops must not write, jump or branch, so the whole bundle is cleared.
      if (bad)
         c = '0;
   end

   assign ctrl    = c;
   assign illegal = bad;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: decodes an instruction and holds it in a 2-entry skid buffer.
// Define RV32M_DECODE_EN to enable RV32M decode in the ctrl_decode sub-module.
module decode_ctrl_stage
   import ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      instr_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic             flush_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output ctrl_bundle_t     ctrl_o,
   output logic [4:0]       rd_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [XLEN-1:0]  pc_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   typedef struct packed {
      ctrl_bundle_t    ctrl;
      logic            illegal;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] pc;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

   state_e           state, state_nxt;
   entry_t           head, skid, dec_e;
   logic             accept, pop;
   logic             head_ld_new, head_ld_skid, skid_ld;
   logic             in_ready_q;
   logic [CNT_W-1:0] cnt;

   ctrl_decode u_dec (
      .instr   (instr_i),
      .ctrl    (dec_e.ctrl),
      .illegal (dec_e.illegal),
      .rd      (dec_e.rd),
      .rs1     (dec_e.rs1),
      .rs2     (dec_e.rs2)
   );
   assign dec_e.pc = pc_i;

   assign accept      = in_valid_i & in_ready_q;
   assign out_valid_o = (state != EMPTY);
   assign pop         = out_valid_o & out_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      head_ld_new  = 1'b0;
      head_ld_skid = 1'b0;
      skid_ld      = 1'b0;
      case (state)
         EMPTY: if (accept) begin
            state_nxt   = ONE;
            head_ld_new = 1'b1;
         end
         ONE: begin
            if (accept && pop) begin
               head_ld_new = 1'b1;
            end else if (accept) begin
               state_nxt = TWO;
               skid_ld   = 1'b1;
            end else if (pop) begin
               state_nxt = EMPTY;
            end
         end
         TWO: if (pop) begin
            state_nxt    = ONE;
            head_ld_skid = 1'b1;
         end
         default: state_nxt = EMPTY;
      endcase
      // A redirect discards everything, including whatever is accepted this cycle.
      if (flush_i) begin
         state_nxt    = EMPTY;
         head_ld_new  = 1'b0;
         head_ld_skid = 1'b0;
         skid_ld      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head       <= '0;
         skid       <= '0;
         in_ready_q <= 1'b1;
         cnt        <= '0;
      end else begin
         if (head_ld_new)       head <= dec_e;
         else if (head_ld_skid) head <= skid;
         if (skid_ld)           skid <= dec_e;
         in_ready_q <= (state_nxt != TWO);
         if (accept && dec_e.illegal && !flush_i && cnt != '1)
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign in_ready_o    = in_ready_q;
   assign ctrl_o        = head.ctrl;
   assign rd_o          = head.rd;
   assign rs1_o         = head.rs1;
   assign rs2_o         = head.rs2;
   assign pc_o          = head.pc;
   assign illegal_o     = head.illegal;
   assign illegal_cnt_o = cnt;

endmodule
